pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on pll_locked (minimum 2).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 8, the pll_rst pulse length in clocks (minimum 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, the maximum number of clocks to wait for lock before a retry.
REQ-004 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the number of consecutive locked clocks required before reset release.
REQ-005 SHALL have port clk_74a, input, 1 bit: the single clock, free-running and independent of the PLL.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk_74a.
REQ-008 SHALL have port relock_req, input, 1 bit: single-cycle request to force a PLL reset sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-010 SHALL have port sys_rst_n, output, 1 bit: active-low reset for logic clocked by the PLL outputs.
REQ-011 SHALL have port pll_ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port retry_count, output, 8 bits: number of lock timeouts, saturating.
REQ-013 SHALL have port loss_count, output, 8 bits: number of lock losses seen in RUN, saturating.

Function
REQ-014 SHALL pass pll_locked through an SYNC_STAGES flop synchronizer; all logic SHALL use only the synchronized value, locked_s.
REQ-015 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE and RUN.
REQ-016 PLL_RST SHALL drive pll_rst=1 for exactly PLL_RST_CYCLES clocks, then go to WAIT_LOCK with the cycle counter cleared.
REQ-017 WAIT_LOCK SHALL go to STABLE on locked_s=1; if LOCK_TIMEOUT_CYCLES elapse without lock, it SHALL go to PLL_RST and increment retry_count.
REQ-018 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive clocks of locked_s=1; any locked_s=0 SHALL return it to WAIT_LOCK with the counter cleared, with no retry increment.
REQ-019 RUN SHALL drive sys_rst_n=1 and pll_ready=1.
REQ-020 In RUN, locked_s=0 SHALL drive sys_rst_n=0 and pll_ready=0 on the next edge, increment loss_count and go to PLL_RST.
REQ-021 relock_req=1 in any state SHALL go to PLL_RST with the counter cleared; an active pll_rst pulse SHALL restart at full length; counters SHALL NOT change.
REQ-022 When relock_req and lock loss occur in the same cycle in RUN, relock_req SHALL win and loss_count SHALL NOT increment.
REQ-023 sys_rst_n SHALL be 0 in every state except RUN; it SHALL assert asynchronously with reset_n and deassert synchronously.
REQ-024 Counters SHALL saturate at 255 and never wrap.
REQ-025 The cycle counter width SHALL be clog2 of the largest timing parameter plus 1.

Reset
REQ-026 reset_n=0 SHALL immediately force state PLL_RST, pll_rst=1, sys_rst_n=0, pll_ready=0, cycle counter 0, retry_count 0, loss_count 0 and the synchronizer to 0.
REQ-027 After reset_n rises, the full PLL_RST_CYCLES pulse SHALL be generated.
REQ-028 reset_n asserted mid-sequence SHALL abandon the sequence and clear all counters.

Configuration
REQ-029 With PLL_SUP_STATUS_EN defined, the retry_count and loss_count registers and their logic SHALL be built.
REQ-030 Without PLL_SUP_STATUS_EN, retry_count and loss_count SHALL be constant 0 and no counter flops SHALL be inferred; state behaviour SHALL be identical.

Structure
REQ-031 Package pll_sup_pkg SHALL hold the state enum, the STATUS_W=8 constant and the saturating-increment function.
REQ-032 Sub-module pll_sup_sync SHALL implement the SYNC_STAGES-deep bit synchronizer with asynchronous active-low reset.

Verification (PLL_RST_CYCLES=8, LOCK_TIMEOUT_CYCLES=256, LOCK_STABLE_CYCLES=16, SYNC_STAGES=2)
REQ-033 Release reset, raise pll_locked at cycle 20 -> pll_rst high for exactly cycles 0-7; sys_rst_n rises 2+16 clocks after locked rises; pll_ready=1.
REQ-034 Hold pll_locked=0 -> pll_rst re-pulses every 8+256 clocks; retry_count counts 1, 2, 3 and saturates at 255 after 255 timeouts.
REQ-035 In RUN, drop pll_locked for 1 clock -> sys_rst_n=0 within 3 clocks, loss_count=1, a pll_rst pulse of 8 clocks, then reacquire.
REQ-036 In STABLE, glitch pll_locked low at stable count 10 -> the count restarts and sys_rst_n rises 16 clocks after the glitch ends; retry_count unchanged.
REQ-037 Pulse relock_req in the same cycle as lock loss in RUN -> a pll_rst pulse of 8 clocks and loss_count unchanged.
REQ-038 Assert reset_n=0 asynchronously in the middle of STABLE -> outputs reach their reset values with no clock edge, and the counters read 0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_sup_state_e;

  localparam int unsigned STATUS_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STATUS_W-1:0] sat_inc(input logic [STATUS_W-1:0] v);
    return (v == '1) ? v : v + STATUS_W'(1);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// pll_sup_sync: SYNC_STAGES-deep single-bit synchronizer, async active-low reset.
module pll_sup_sync
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for a stable lock and
// releases the downstream reset; re-sequences on timeout, lock loss or request.
// Optional build macro PLL_SUP_STATUS_EN adds the saturating retry/loss counters;
// without it both status outputs are tied to zero.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input  logic                clk_74a,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                relock_req,
  output logic                pll_rst,
  output logic                sys_rst_n,
  output logic                pll_ready,
  output logic [STATUS_W-1:0] retry_count,
  output logic [STATUS_W-1:0] loss_count
);

  localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                                      CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  pll_sup_state_e   r_state;
  pll_sup_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_locked_s;
  logic             w_retry_inc;
  logic             w_loss_inc;
  logic             r_pll_rst;
  logic             r_run;

  pll_sup_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk_74a),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // State and cycle counter registers.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_PLL_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; relock_req overrides everything, including lock loss.
  // The WAIT_LOCK cycle that first sees lock counts as the first stable clock.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    if (relock_req) begin
      w_state_nxt = ST_PLL_RST;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            if (LOCK_STABLE_CYCLES <= 1) begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_STABLE;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt = ST_PLL_RST;
            w_cnt_nxt   = '0;
            w_retry_inc = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STB_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_PLL_RST;
            w_cnt_nxt   = '0;
            w_loss_inc  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Registered outputs decoded from the next state so they are glitch-free.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_pll_rst <= 1'b1;
      r_run     <= 1'b0;
    end else begin
      r_pll_rst <= (w_state_nxt == ST_PLL_RST);
      r_run     <= (w_state_nxt == ST_RUN);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_run;
  assign pll_ready = r_run;

`ifdef PLL_SUP_STATUS_EN
  logic [STATUS_W-1:0] r_retry;
  logic [STATUS_W-1:0] r_loss;

  // Saturating timeout and lock-loss counters.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_retry <= '0;
      r_loss  <= '0;
    end else begin
      if (w_retry_inc) r_retry <= sat_inc(r_retry);
      if (w_loss_inc)  r_loss  <= sat_inc(r_loss);
    end
  end

  assign retry_count = r_retry;
  assign loss_count  = r_loss;
`else
  logic w_unused_status;
  assign w_unused_status = w_retry_inc | w_loss_inc;
  assign retry_count     = '0;
  assign loss_count      = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed stimulus with an event scoreboard; every
// output transition must match the next expected event in time and value.
module tb_pll_lock_supervisor;

  logic       clk_74a;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_ready;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (8),
    .LOCK_TIMEOUT_CYCLES(256),
    .LOCK_STABLE_CYCLES (16)
  ) dut (
    .clk_74a    (clk_74a),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  typedef struct {
    int   cyc;
    logic prst;
    logic srn;
    logic rdy;
    int   rc;
    int   lc;
  } ev_t;

  ev_t  q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [20:0] prev = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

  initial clk_74a = 1'b0;
  always #5 clk_74a = ~clk_74a;

  always @(posedge clk_74a) cyc <= cyc + 1;

  function automatic int ev(input int v);
`ifdef PLL_SUP_STATUS_EN
    return v;
`else
    return (v < 0) ? 0 : 0;
`endif
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic push(input int c, input logic p, input logic s, input logic r,
                      input int rc, input int lc);
    ev_t e;
    e.cyc = c; e.prst = p; e.srn = s; e.rdy = r; e.rc = ev(rc); e.lc = ev(lc);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk_74a);
  endtask

  // Monitor: any output change while out of reset must match the next expected event.
  always @(negedge clk_74a) begin
    logic [20:0] cur;
    ev_t e;
    cur = {pll_rst, sys_rst_n, pll_ready, retry_count, loss_count};
    if (reset_n && cur != prev) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: cyc=%0d prst=%0b srn=%0b rdy=%0b retry=%0d loss=%0d",
                 cyc, pll_rst, sys_rst_n, pll_ready, retry_count, loss_count);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.prst !== pll_rst || e.srn !== sys_rst_n ||
            e.rdy !== pll_ready || e.rc != int'(retry_count) || e.lc != int'(loss_count)) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d prst=%0b srn=%0b rdy=%0b retry=%0d loss=%0d, expected cyc=%0d prst=%0b srn=%0b rdy=%0b retry=%0d loss=%0d",
                   cyc, pll_rst, sys_rst_n, pll_ready, retry_count, loss_count,
                   e.cyc, e.prst, e.srn, e.rdy, e.rc, e.lc);
        end
      end
    end
    prev = cur;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_pll_rst",   int'(pll_rst),     1);
    chk("reset_sys_rst_n", int'(sys_rst_n),   0);
    chk("reset_pll_ready", int'(pll_ready),   0);
    chk("reset_retry",     int'(retry_count), 0);
    chk("reset_loss",      int'(loss_count),  0);
    repeat (3) @(negedge clk_74a);

    // Power-up: full reset pulse, lock at cycle 20, release 2+16 later.
    b = cyc;
    push(b + 8,  1'b0, 1'b0, 1'b0, 0, 0);
    push(b + 38, 1'b0, 1'b1, 1'b1, 0, 0);
    reset_n = 1'b1;
    go(b + 20);
    pll_locked = 1'b1;
    go(b + 45);

    // One-clock lock drop in RUN.
    b = cyc;
    push(b + 3,  1'b1, 1'b0, 1'b0, 0, 1);
    push(b + 11, 1'b0, 1'b0, 1'b0, 0, 1);
    push(b + 27, 1'b0, 1'b1, 1'b1, 0, 1);
    pll_locked = 1'b0;
    @(negedge clk_74a);
    pll_locked = 1'b1;
    go(b + 35);

    // Relock, then a glitch seen by STABLE at stable count 10.
    b = cyc;
    push(b + 1,  1'b1, 1'b0, 1'b0, 0, 1);
    push(b + 9,  1'b0, 1'b0, 1'b0, 0, 1);
    push(b + 36, 1'b0, 1'b1, 1'b1, 0, 1);
    relock_req = 1'b1;
    @(negedge clk_74a);
    relock_req = 1'b0;
    go(b + 17);
    pll_locked = 1'b0;
    @(negedge clk_74a);
    pll_locked = 1'b1;
    go(b + 45);

    // Relock in the same cycle the loss reaches the FSM: no loss count.
    b = cyc;
    push(b + 3,  1'b1, 1'b0, 1'b0, 0, 1);
    push(b + 11, 1'b0, 1'b0, 1'b0, 0, 1);
    push(b + 27, 1'b0, 1'b1, 1'b1, 0, 1);
    pll_locked = 1'b0;
    @(negedge clk_74a);
    pll_locked = 1'b1;
    @(negedge clk_74a);
    relock_req = 1'b1;
    @(negedge clk_74a);
    relock_req = 1'b0;
    go(b + 35);

    // Relock during an active pll_rst pulse restarts it at full length.
    b = cyc;
    push(b + 1,  1'b1, 1'b0, 1'b0, 0, 1);
    push(b + 13, 1'b0, 1'b0, 1'b0, 0, 1);
    push(b + 29, 1'b0, 1'b1, 1'b1, 0, 1);
    relock_req = 1'b1;
    @(negedge clk_74a);
    relock_req = 1'b0;
    go(b + 4);
    relock_req = 1'b1;
    @(negedge clk_74a);
    relock_req = 1'b0;
    go(b + 35);

    // Lock lost for good: loss, then 256 timeouts with retry saturating at 255.
    b = cyc;
    push(b + 3,  1'b1, 1'b0, 1'b0, 0, 2);
    push(b + 11, 1'b0, 1'b0, 1'b0, 0, 2);
    for (int n = 1; n <= 256; n++) begin
      push(b + 3 + n * 264,  1'b1, 1'b0, 1'b0, sat(n), 2);
      push(b + 11 + n * 264, 1'b0, 1'b0, 1'b0, sat(n), 2);
    end
    pll_locked = 1'b0;
    go(b + 11 + 256 * 264 + 2);

    // Lock again, then reset asynchronously while in STABLE.
    b = cyc;
    pll_locked = 1'b1;
    go(b + 8);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pll_rst",   int'(pll_rst),     1);
    chk("async_sys_rst_n", int'(sys_rst_n),   0);
    chk("async_pll_ready", int'(pll_ready),   0);
    chk("async_retry",     int'(retry_count), 0);
    chk("async_loss",      int'(loss_count),  0);
    repeat (2) @(negedge clk_74a);

    // Release again: full pulse and normal acquisition with cleared counters.
    b = cyc;
    push(b + 8,  1'b0, 1'b0, 1'b0, 0, 0);
    push(b + 24, 1'b0, 1'b1, 1'b1, 0, 0);
    reset_n = 1'b1;
    go(b + 30);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk_74a);
    chk("events_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
